// File: rtl/bfm_sched_pkg.sv
// Shared types and constants for the bfm round-robin scheduler.
package bfm_sched_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int MAX_REQ    = 8;
    localparam int ID_W       = $clog2(MAX_REQ);

    // Sized for MAX_REQ so one type serves every NUM_REQ setting.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/bfm_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bfm_rr_scheduler.sv
// Round-robin sharing of one bfm operand datapath among NUM_REQ requesters;
// a tag pipe matched to BFM_LAT routes each result back to its issuer.
module bfm_rr_scheduler
    import bfm_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BFM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      en_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [DATA_W-1:0]         A_s,
    output logic [DATA_W-1:0]         B_s,
    input  logic [DATA_W-1:0]         bfm_res_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          issue_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic               fire;
    tag_t               new_tag;
    tag_t               tag_pipe [BFM_LAT];
    tag_t               tail;
    logic               any_tag;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Ready is the grant itself, so valid & ready reduces to fire.
    assign fire        = en_i & ~reset_i & pick_any;
    assign req_ready_o = fire ? pick_grant : '0;

    always_comb begin
        new_tag       = '0;
        new_tag.valid = fire;
        new_tag.id    = fire ? ID_W'(pick_idx) : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            A_s         <= '0;
            B_s         <= '0;
            rr_ptr      <= '0;
            issue_cnt_o <= '0;
            for (int i = 0; i < BFM_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= new_tag;
            for (int i = 1; i < BFM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (fire) begin
                A_s    <= req_a_i[pick_idx*DATA_W +: DATA_W];
                B_s    <= req_b_i[pick_idx*DATA_W +: DATA_W];
                rr_ptr <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                if (issue_cnt_o != '1) issue_cnt_o <= issue_cnt_o + 1'b1;
            end else begin
                // Bubble: zero operands keep the bfm output idle.
                A_s <= '0;
                B_s <= '0;
            end
        end
    end

    assign tail = tag_pipe[BFM_LAT-1];

    always_comb begin
        rsp_valid_o = '0;
        any_tag     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid_o[i] = tail.valid && (tail.id == ID_W'(i));
        for (int i = 0; i < BFM_LAT; i++)
            any_tag = any_tag | tag_pipe[i].valid;
    end

    assign rsp_data_o = tail.valid ? bfm_res_i : '0;
    assign busy_o     = any_tag | (|req_ready_o);

endmodule

// File: tb/tb_bfm_rr_scheduler.sv
// Scoreboard bench: driver predicts grants/responses from a reference model, monitor checks at negedge.
module tb_bfm_rr_scheduler;

    localparam int NR = 2;
    localparam int DW = 8;
    localparam int CW = 32;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              en_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*DW-1:0]  req_a_i;
    logic [NR*DW-1:0]  req_b_i;
    logic [DW-1:0]     A_s, B_s, bfm_res_i, rsp_data_o;
    logic [NR-1:0]     rsp_valid_o;
    logic              busy_o;
    logic [CW-1:0]     issue_cnt_o;

    always #5 clk_i = ~clk_i;

    // bfm stand-in: combinational sum gives a one-cycle result after the operand register.
    assign bfm_res_i = A_s + B_s;

    bfm_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .BFM_LAT(1), .CNT_W(CW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .A_s         (A_s),
        .B_s         (B_s),
        .bfm_res_i   (bfm_res_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .issue_cnt_o (issue_cnt_o)
    );

    typedef struct {
        int       id;
        logic [7:0] data;
        int       due;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            ptr   = 0, nxt_ptr = 0;
    logic [7:0]    cur_a = 0, cur_b = 0, nxt_a = 0, nxt_b = 0;
    logic [31:0]   cur_cnt = 0, nxt_cnt = 0;
    logic [NR-1:0] exp_ready = 0;
    int            grants [NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides the grant from the round-robin rule.
    task automatic step(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic en);
        int g;
        logic [7:0] a, b;
        @(posedge clk_i);
        #1;
        cyc++;
        cur_a = nxt_a; cur_b = nxt_b; cur_cnt = nxt_cnt; ptr = nxt_ptr;
        req_valid_i = v;
        req_a_i     = {a1, a0};
        req_b_i     = {b1, b0};
        en_i        = en;
        g = -1;
        if (en) for (int k = 0; k < NR; k++) if (g < 0 && v[(ptr + k) % NR]) g = (ptr + k) % NR;
        if (g >= 0) begin
            a = (g == 1) ? a1 : a0;
            b = (g == 1) ? b1 : b0;
            exp_ready = NR'(1) << g;
            nxt_a = a; nxt_b = b;
            nxt_ptr = (g + 1) % NR;
            nxt_cnt = (cur_cnt == 32'hFFFF_FFFF) ? cur_cnt : cur_cnt + 1;
            grants[g]++;
            expq.push_back('{g, 8'(a + b), cyc + 1});
        end else begin
            exp_ready = '0;
            nxt_a = 0; nxt_b = 0; nxt_ptr = ptr; nxt_cnt = cur_cnt;
        end
    endtask

    task automatic clear_model();
        expq.delete();
        cur_a = 0; cur_b = 0; nxt_a = 0; nxt_b = 0;
        cur_cnt = 0; nxt_cnt = 0; ptr = 0; nxt_ptr = 0; exp_ready = '0;
        grants[0] = 0; grants[1] = 0;
    endtask

    // Monitor: compares every output once per cycle on the falling edge.
    initial begin
        forever begin
            logic tail_due;
            @(negedge clk_i);
            tail_due = (expq.size() > 0) && (expq[0].due == cyc);
            chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
            chk("A_s", 32'(A_s), 32'(cur_a));
            chk("B_s", 32'(B_s), 32'(cur_b));
            chk("issue_cnt", issue_cnt_o, cur_cnt);
            chk("busy", 32'(busy_o), 32'(tail_due | (|exp_ready)));
            if (tail_due) begin
                exp_t e;
                e = expq.pop_front();
                chk("rsp_valid", 32'(rsp_valid_o), 32'(NR'(1) << e.id));
                chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid_o), 32'd0);
                chk("rsp_data_idle", 32'(rsp_data_o), 32'd0);
            end
        end
    end

    initial begin
        reset_i = 1'b1; en_i = 1'b0; req_valid_i = '0; req_a_i = '0; req_b_i = '0;
        clear_model();
        repeat (2) @(posedge clk_i);
        #3 reset_i = 1'b0;

        // Single requester, five back-to-back ops.
        for (int i = 0; i < 5; i++) step(2'b01, 8'd1, 8'd2, 8'd0, 8'd0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        chk("issue_cnt_single", issue_cnt_o, 32'd5);

        // Both valid: grants alternate.
        clear_model();
        reset_i = 1'b1; #1 reset_i = 1'b0;
        for (int i = 0; i < 8; i++) step(2'b11, 8'd10, 8'd20, 8'd100, 8'd55, 1'b1);
        chk("equal_grants", 32'(grants[0]), 32'(grants[1]));
        chk("grants_four", 32'(grants[0]), 32'd4);

        // Result wrap on requester 1.
        step(2'b10, 8'd0, 8'd0, 8'd200, 8'd100, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);

        // Enable low with both valid; in-flight response still arrives.
        step(2'b11, 8'd3, 8'd4, 8'd5, 8'd6, 1'b1);
        for (int i = 0; i < 3; i++) step(2'b11, 8'd3, 8'd4, 8'd5, 8'd6, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b11, 8'd7, 8'd8, 8'd9, 8'd10, 1'b1);

        // Async reset between edges with one op in flight.
        step(2'b01, 8'd40, 8'd2, 8'd0, 8'd0, 1'b1);
        @(posedge clk_i);
        #1 cyc++;
        #2 reset_i = 1'b1;
        req_valid_i = '0;
        clear_model();
        #1;
        chk("rst_A_s", 32'(A_s), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        chk("rst_issue_cnt", issue_cnt_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1 cyc++;
        #2 reset_i = 1'b0;
        step(2'b00, 0, 0, 0, 0, 1'b1);

        // Fairness: requester 1 joins at cycle 3.
        for (int i = 0; i < 8; i++) step((i >= 3) ? 2'b11 : 2'b01, 8'd1, 8'd1, 8'd2, 8'd2, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 7) != 0));
        step(2'b00, 0, 0, 0, 0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 1'b1);
        @(posedge clk_i);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
